// File: rtl/adder_pkg.sv
// Shared helpers for the segmented, carry-pipelined adder family.
package adder_pkg;

    // Ceiling log2 for elaboration-time sizing (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Legal geometry: SEG is a power of two >= 4 and divides WIDTH exactly.
    function automatic bit widths_legal(input int unsigned width, input int unsigned seg);
        return (seg >= 4) && ((seg & (seg - 1)) == 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/prefix_segment_adder.sv
// Combinational SEG-bit adder with a Kogge-Stone carry network.
module prefix_segment_adder
    import adder_pkg::*;
#(
    parameter int unsigned SEG = 16
) (
    output logic [SEG-1:0] sum,
    output logic           cout,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin
);
    localparam int unsigned LVL = clog2(SEG);

    logic [SEG-1:0]          hp;
    logic [LVL:0][SEG-1:0]   g;
    logic [LVL-1:0][SEG-1:0] p;

    // cin is folded into bit 0's generate and bit 0's propagate forced to 0, so
    // every prefix that already reaches bit 0 has p=0; that lets resolved
    // positions combine with themselves instead of needing a separate pass-through.
    assign hp   = a ^ b;
    assign g[0] = (a & b) | {{(SEG-1){1'b0}}, hp[0] & cin};
    assign p[0] = {hp[SEG-1:1], 1'b0};

    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        for (genvar i = 0; i < SEG; i++) begin : g_bit
            localparam int J = (i >= (1 << l)) ? i - (1 << l) : i;
            assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
            if (l + 1 < LVL) begin : g_prop
                assign p[l+1][i] = p[l][i] & p[l][J];
            end
        end
    end

    assign sum  = hp ^ {g[LVL][SEG-2:0], cin};
    assign cout = g[LVL][SEG-1];

endmodule

// File: rtl/pipelined_segment_adder.sv
// WIDTH-bit add/subtract, one SEG-bit segment per pipeline stage, with a
// global-stall valid/ready handshake. Latency NSEG, throughput 1/cycle.
module pipelined_segment_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NSEG = WIDTH / SEG;

    if (!widths_legal(WIDTH, SEG)) begin : g_bad_geometry
        $error("pipelined_segment_adder: WIDTH must be a multiple of SEG, SEG a power of two >= 4");
    end

    // a_rem/b_rem are shifted right one segment per stage, so the segment to be
    // added next always sits in bits [SEG-1:0].
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic             carry;
        logic             sa;
        logic             sb;
    } stage_t;

    stage_t           st [NSEG];
    logic [SEG-1:0]   seg_sum [NSEG];
    logic             seg_cout [NSEG];
    logic [WIDTH-1:0] beff;
    logic             c0;
    logic             stall;
    logic             accept;

    assign beff     = sub ? ~b : b;
    assign c0       = sub | cin;
    assign stall    = st[NSEG-1].valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == 0) begin : g_first
            prefix_segment_adder #(.SEG(SEG)) u_seg (
                .sum  (seg_sum[k]),
                .cout (seg_cout[k]),
                .a    (a[SEG-1:0]),
                .b    (beff[SEG-1:0]),
                .cin  (c0)
            );
        end else begin : g_next
            prefix_segment_adder #(.SEG(SEG)) u_seg (
                .sum  (seg_sum[k]),
                .cout (seg_cout[k]),
                .a    (st[k-1].a_rem[SEG-1:0]),
                .b    (st[k-1].b_rem[SEG-1:0]),
                .cin  (st[k-1].carry)
            );
        end
    end

    // Pipeline shift: whole pipe freezes on stall; data only loads behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NSEG; k++) st[k] <= '0;
        end else if (!stall) begin
            st[0].valid <= accept;
            if (accept) begin
                st[0].psum  <= WIDTH'(seg_sum[0]);
                st[0].a_rem <= a >> SEG;
                st[0].b_rem <= beff >> SEG;
                st[0].carry <= seg_cout[0];
                st[0].sa    <= a[WIDTH-1];
                st[0].sb    <= beff[WIDTH-1];
            end
            for (int unsigned k = 1; k < NSEG; k++) begin
                st[k].valid <= st[k-1].valid;
                if (st[k-1].valid) begin
                    st[k].psum  <= st[k-1].psum | (WIDTH'(seg_sum[k]) << (k * SEG));
                    st[k].a_rem <= st[k-1].a_rem >> SEG;
                    st[k].b_rem <= st[k-1].b_rem >> SEG;
                    st[k].carry <= seg_cout[k];
                    st[k].sa    <= st[k-1].sa;
                    st[k].sb    <= st[k-1].sb;
                end
            end
        end
    end

    assign out_valid = st[NSEG-1].valid;
    assign sum       = st[NSEG-1].psum;
    assign cout      = st[NSEG-1].carry;
    assign ovf       = (st[NSEG-1].sa == st[NSEG-1].sb) & (st[NSEG-1].psum[WIDTH-1] != st[NSEG-1].sa);

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Self-checking bench: 32/16 instance for directed/table tests, 64/16 for random.
module tb_pipelined_segment_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic        use64;

    logic        iv32, ir32, ov32, co32, of32;
    logic [31:0] sum32;
    logic        iv64, ir64, ov64, co64, of64;
    logic [63:0] sum64;

    logic        cur_ov, cur_ir, cur_co, cur_of;
    logic [63:0] cur_sum;

    assign iv32    = in_valid & ~use64;
    assign iv64    = in_valid & use64;
    assign cur_ov  = use64 ? ov64 : ov32;
    assign cur_ir  = use64 ? ir64 : ir32;
    assign cur_co  = use64 ? co64 : co32;
    assign cur_of  = use64 ? of64 : of32;
    assign cur_sum = use64 ? sum64 : {32'b0, sum32};

    pipelined_segment_adder #(.WIDTH(32), .SEG(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .cout(co32), .ovf(of32)
    );

    pipelined_segment_adder #(.WIDTH(64), .SEG(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov64), .out_ready(out_ready), .sum(sum64), .cout(co64), .ovf(of64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] sum; logic cout; logic ovf; } res_t;
    typedef struct { res_t r; int acc_cyc; int acc_stall; bit seen; } sb_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic cin; logic sub;
                     logic [31:0] sum; logic cout; logic ovf; } vec_t;

    sb_t  sb[$];
    vec_t vt[10];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference, independent of segment structure.
    function automatic res_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic c, input logic s, input logic w64);
        res_t        r;
        logic [64:0] full;
        logic [63:0] be;
        logic        c0;
        be = s ? ~bv : bv;
        c0 = s ? 1'b1 : c;
        if (w64) begin
            full   = {1'b0, av} + {1'b0, be} + 65'(c0);
            r.sum  = full[63:0];
            r.cout = full[64];
            r.ovf  = (av[63] == be[63]) && (full[63] != av[63]);
        end else begin
            full   = {33'b0, av[31:0]} + {33'b0, be[31:0]} + 65'(c0);
            r.sum  = {32'b0, full[31:0]};
            r.cout = full[32];
            r.ovf  = (av[31] == be[31]) && (full[31] != av[31]);
        end
        return r;
    endfunction

    // One clock cycle: drive at negedge, evaluate the handshakes the next posedge will take.
    task automatic step(input logic v, input logic [63:0] av, input logic [63:0] bv,
                        input logic c, input logic s, input logic rdy,
                        input res_t exp_r, output logic acc);
        int   nseg;
        logic exp_ir;
        sb_t  e;
        @(negedge clk);
        in_valid = v; a = av; b = bv; cin = c; sub = s; out_ready = rdy;
        #1;
        cyc++;
        nseg   = use64 ? 4 : 2;
        exp_ir = !(cur_ov && !rdy);
        chk("in_ready", cur_ir, exp_ir);
        acc = v && exp_ir;
        if (cur_ov) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_valid: got out_valid=1 expected 0 with nothing pending");
            end else begin
                e = sb[0];
                if (!e.seen) begin
                    chk("latency", cyc - e.acc_cyc, nseg + stall_cnt - e.acc_stall);
                    e.seen = 1'b1;
                    sb[0] = e;
                end
                chk(rdy ? "result" : "hold", {cur_co, cur_of, cur_sum}, {e.r.cout, e.r.ovf, e.r.sum});
                if (rdy) void'(sb.pop_front());
            end
        end
        if (acc) begin
            e.r = exp_r; e.acc_cyc = cyc; e.acc_stall = stall_cnt; e.seen = 1'b0;
            sb.push_back(e);
        end
        if (cur_ov && !rdy) stall_cnt++;
    endtask

    task automatic issue_vec(input int i, input logic v, input logic rdy, output logic acc);
        res_t r;
        r.sum = {32'b0, vt[i].sum}; r.cout = vt[i].cout; r.ovf = vt[i].ovf;
        step(v, {32'b0, vt[i].a}, {32'b0, vt[i].b}, vt[i].cin, vt[i].sub, rdy, r, acc);
    endtask

    task automatic drain(input string name);
        logic acc;
        res_t z;
        z.sum = '0; z.cout = 1'b0; z.ovf = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, z, acc);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          k, held, n_acc;
        logic [63:0] ra, rb;
        logic        rc, rs;
        res_t        z;
        z.sum = '0; z.cout = 1'b0; z.ovf = 1'b0;

        //        a             b             cin   sub   sum           cout  ovf
        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[4] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vt[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        vt[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vt[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vt[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; use64 = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid32", ov32, 0);
        chk("rst_outputs32", {co32, of32, sum32}, 0);
        chk("rst_out_valid64", ov64, 0);
        chk("rst_outputs64", {co64, of64, sum64}, 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_in_ready32", ir32, 1);
        chk("rst_in_ready64", ir64, 1);

        // Back-to-back table vectors
        for (int i = 0; i < 10; i++) issue_vec(i, 1'b1, 1'b1, acc);
        drain("b2b_drain");

        // Bubbles: valid every other cycle
        for (int i = 0; i < 10; i++) begin
            issue_vec(i, 1'b1, 1'b1, acc);
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, z, acc);
        end
        drain("bubble_drain");

        // Backpressure: 4 ops, out_ready low for 3 cycles once the first result is valid
        k = 0; held = 0;
        for (int s = 0; s < 30 && (k < 4 || sb.size() > 0); s++) begin
            @(posedge clk); #1;
            issue_vec(k < 4 ? k : 0, k < 4, !(cur_ov && held < 3), acc);
            if (!out_ready) begin
                held++;
                chk("bp_in_ready_low", cur_ir, 0);
            end
            if (acc) k++;
        end
        chk("bp_stall_cycles", held, 3);
        chk("bp_issued", k, 4);
        chk("bp_drain", sb.size(), 0);

        // Reset with two operations in flight
        issue_vec(6, 1'b1, 1'b1, acc);
        issue_vec(7, 1'b1, 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("pre_reset_valid", ov32, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov32, 0);
        chk("midrst_outputs", {co32, of32, sum32}, 0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, z, acc);
            chk("post_reset_valid", ov32, 0);
        end

        // Random 64-bit traffic with random backpressure
        @(negedge clk); use64 = 1'b1;
        n_acc = 0;
        for (int s = 0; s < 6000 && n_acc < 1000; s++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                2: ra = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) rb = 64'h0000_0000_0000_0001;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, ra, rb, rc, rs, $urandom_range(0, 3) != 0,
                 model(ra, rb, rc, rs, 1'b1), acc);
            if (acc) n_acc++;
        end
        chk("rand_accepted", n_acc, 1000);
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
